// File: rtl/esp_uart_tx_if.sv
// Host-side register interface of the ESP32 UART transmitter.
// Carries the byte write strobe/data, the break request and the FIFO/FSM status flags.
// The host drives through the master modport; the transmitter answers through the slave modport.
interface esp_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       send_break;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx_overflow;

    modport master (
        output tx_data,
        output tx_wr,
        output send_break,
        input  tx_full,
        input  tx_empty,
        input  tx_busy,
        input  tx_overflow
    );

    modport slave (
        input  tx_data,
        input  tx_wr,
        input  send_break,
        output tx_full,
        output tx_empty,
        output tx_busy,
        output tx_overflow
    );
endinterface

// File: rtl/esp_uart_tx.sv
// esp_uart_tx: FIFO-buffered 8N1 UART transmitter (LSB first) toward the ESP32, with line BREAK generation.
// Latency: a byte written at edge E0 into an idle transmitter drives the start bit from edge E1; frame = 10 bit periods.
// Backpressure: tx_full refuses writes; a write while full is dropped and flagged by a one-cycle tx_overflow.
// Optional: define ESP_UART_TX_CTS_EN to add the uart_cts_n input; new frames then wait for a synchronised CTS.
module esp_uart_tx #(
    parameter int CLKS_PER_BIT    = 4,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst,
    esp_uart_tx_if.slave host,
`ifdef ESP_UART_TX_CTS_EN
    input  logic         uart_cts_n,
`endif
    output logic         uart_txd
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW    = FIFO_DEPTH_LOG2;

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    // BREAK lasts at least this many bit periods (longer than any legal 10-bit frame).
    localparam logic [3:0] BRK_MIN = 4'd10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          ovf_q;

    // Full is taken from the registered count, so a pop on the same edge never frees room for a write.
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign push       = host.tx_wr && !fifo_full;

    // Storage array: written only on accepted writes, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host.tx_data;
        end
    end

    // Pointers wrap modulo depth; count tracks occupancy, unchanged on simultaneous push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle flag for a write that arrived while the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= host.tx_wr && fifo_full;
        end
    end

    // ------------------------------------------------------------------
    // Clear-to-send gating
    // ------------------------------------------------------------------
    logic cts_ok;

`ifdef ESP_UART_TX_CTS_EN
    logic [1:0] cts_sync;

    // Two-flop synchroniser for the asynchronous CTS line; resets to "not clear".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], uart_cts_n};
        end
    end

    assign cts_ok = !cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    data_idx;
    logic [2:0]    data_idx_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic [3:0]    brk_cnt;
    logic [3:0]    brk_cnt_nxt;
    logic          bit_end;
    logic          frame_go;
    logic          txd_nxt;

    assign bit_end  = (bit_cnt == BIT_LAST);
    assign frame_go = !fifo_empty && cts_ok;

    // Next-state logic; IDLE and the end of STOP share the same break-first, then-next-byte priority.
    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        data_idx_nxt = data_idx;
        brk_cnt_nxt  = brk_cnt;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host.send_break) begin
                    state_nxt   = ST_BREAK;
                    brk_cnt_nxt = 4'd0;
                end else if (frame_go) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt    = ST_DATA;
                    data_idx_nxt = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    if (data_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        data_idx_nxt = data_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (host.send_break) begin
                        state_nxt   = ST_BREAK;
                        brk_cnt_nxt = 4'd0;
                    end else if (frame_go) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (bit_end) begin
                    if (brk_cnt != BRK_MIN) begin
                        brk_cnt_nxt = brk_cnt + 4'd1;
                    end
                    // The period ending now is the tenth (or later) one: release once the host lets go.
                    if ((brk_cnt >= (BRK_MIN - 4'd1)) && !host.send_break) begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so uart_txd changes on the same edge as the state.
    always_comb begin
        case (state_nxt)
            ST_START: txd_nxt = 1'b0;
            ST_BREAK: txd_nxt = 1'b0;
            ST_DATA:  txd_nxt = shift_nxt[0];
            default:  txd_nxt = 1'b1;
        endcase
    end

    // State, bit timer and datapath registers; the bit timer restarts on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            data_idx <= 3'd0;
            shift    <= 8'h00;
            brk_cnt  <= 4'd0;
        end else begin
            state    <= state_nxt;
            data_idx <= data_idx_nxt;
            shift    <= shift_nxt;
            brk_cnt  <= brk_cnt_nxt;
            if ((state_nxt != state) || bit_end || (state == ST_IDLE)) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    // Registered serial output, idle high; reset pulls the line back to mark immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_txd <= 1'b1;
        end else begin
            uart_txd <= txd_nxt;
        end
    end

    assign host.tx_full     = fifo_full;
    assign host.tx_empty    = fifo_empty;
    assign host.tx_busy     = (state != ST_IDLE);
    assign host.tx_overflow = ovf_q;

endmodule

// File: tb/tb_esp_uart_tx.sv
// Testbench for esp_uart_tx: random byte traffic against a line-level reference model,
// plus directed checks of the 0xA5 waveform, FIFO overflow, BREAK timing and mid-frame reset.
// The model predicts each frame's start cycle and the expected line level for every clock.
module tb_esp_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_txd;

    esp_uart_tx_if tif();

`ifdef ESP_UART_TX_CTS_EN
    logic uart_cts_n = 1'b0;
`endif

    esp_uart_tx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (tif),
`ifdef ESP_UART_TX_CTS_EN
        .uart_cts_n (uart_cts_n),
`endif
        .uart_txd   (uart_txd)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every accepted byte gets a frame start cycle: one cycle after its write, or right after the
    // previous frame if the line is still busy. The FIFO occupancy follows from those start cycles.
    int         starts[$];
    logic [7:0] bytes[$];
    int         n_acc;
    int         next_free;
    int         cyc;

    task automatic model_clear();
        starts.delete();
        bytes.delete();
        n_acc     = 0;
        next_free = 0;
    endtask

    function automatic int n_started(input int e);
        int n;
        n = 0;
        foreach (starts[k]) begin
            if (starts[k] <= e) n++;
        end
        return n;
    endfunction

    function automatic logic exp_line(input int c);
        logic [7:0] b;
        int         bn;
        foreach (starts[k]) begin
            if (c >= starts[k] && c < starts[k] + FRAME) begin
                bn = (c - starts[k]) / CPB;
                b  = bytes[k];
                if (bn == 0) return 1'b0;
                if (bn == 9) return 1'b1;
                return b[bn - 1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int c);
        foreach (starts[k]) begin
            if (c >= starts[k] && c < starts[k] + FRAME) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: optionally write a byte, then check all host-visible outputs against the model.
    task automatic step(input logic wr, input logic [7:0] d);
        int   e;
        int   pend;
        int   s;
        int   occ;
        logic acc;
        e    = cyc + 1;
        pend = n_acc - n_started(e - 1);
        acc  = wr && (pend < DEPTH);
        tif.tx_wr   = wr;
        tif.tx_data = d;
        @(posedge clk);
        cyc = e;
        #1;
        tif.tx_wr = 1'b0;
        if (acc) begin
            s = (e + 1 > next_free) ? e + 1 : next_free;
            starts.push_back(s);
            bytes.push_back(d);
            next_free = s + FRAME;
            n_acc++;
        end
        occ = n_acc - n_started(e);
        chk_val("txd",      uart_txd,        exp_line(e));
        chk_val("busy",     tif.tx_busy,     exp_busy(e));
        chk_val("empty",    tif.tx_empty,    occ == 0);
        chk_val("full",     tif.tx_full,     occ == DEPTH);
        chk_val("overflow", tif.tx_overflow, wr && !acc);
    endtask

    // ---------------- line capture for BREAK tests ----------------
    logic line   [0:127];
    logic busy_l [0:127];

    // send_break is active for edges brk_on..brk_off-1; an optional byte is written on edge 0.
    task automatic run_line(input int n, input int brk_on, input int brk_off,
                            input logic wr0, input logic [7:0] d);
        tif.send_break = (brk_on == 0);
        tif.tx_wr      = wr0;
        tif.tx_data    = d;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            line[i]   = uart_txd;
            busy_l[i] = tif.tx_busy;
            tif.tx_wr = 1'b0;
            if (i + 1 == brk_on)  tif.send_break = 1'b1;
            if (i + 1 == brk_off) tif.send_break = 1'b0;
        end
    endtask

    initial begin
        logic       pat [10];
        logic [7:0] fb;
        int         ovf_seen;
        int         cnt;
        int         p;

        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tif.tx_wr      = 1'b0;
        tif.tx_data    = 8'h00;
        tif.send_break = 1'b0;
        cyc = 0;
        model_clear();

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_txd",   uart_txd,        1'b1);
        chk_val("rst_full",  tif.tx_full,     1'b0);
        chk_val("rst_empty", tif.tx_empty,    1'b1);
        chk_val("rst_busy",  tif.tx_busy,     1'b0);
        chk_val("rst_ovf",   tif.tx_overflow, 1'b0);
        rst = 1'b0;

        repeat (5) step(1'b0, 8'h00);

        // Single 0xA5 at idle: line stays high on the write edge, then the 10 bits, 4 clk each.
        step(1'b1, 8'hA5);
        chk_val("a5_write_edge", uart_txd, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 8'h00);
            if (i % CPB == CPB / 2) chk_val("a5_bit", uart_txd, pat[i / CPB]);
        end
        repeat (8) step(1'b0, 8'h00);

        // Three back-to-back bytes form contiguous frames.
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h55);
        repeat (3 * FRAME + 10) step(1'b0, 8'h00);

        // Overflow: 18 consecutive writes from idle; the first is popped at once, the 18th is dropped.
        ovf_seen = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, 8'h30 + 8'(i));
            if (tif.tx_overflow) ovf_seen++;
        end
        chk_val("ovf_full_after", tif.tx_full, 1'b1);
        for (int i = 0; i < (DEPTH + 2) * FRAME + 10; i++) begin
            step(1'b0, 8'h00);
            if (tif.tx_overflow) ovf_seen++;
        end
        chk_val("ovf_pulses", ovf_seen, 1);

        // Random traffic with varying write density.
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       p = 5;
                1:       p = 30;
                default: p = 90;
            endcase
            for (int i = 0; i < 250; i++) begin
                step($urandom_range(0, 99) < p, 8'($urandom));
            end
        end
        repeat ((DEPTH + 1) * FRAME + 10) step(1'b0, 8'h00);

        // Standalone BREAK held 5 bit periods: minimum 40 clk low, then a 1-bit STOP mark.
        run_line(60, 0, 5 * CPB, 1'b0, 8'h00);
        cnt = 0;
        for (int i = 0; i < 40; i++) if (line[i] == 1'b0) cnt++;
        chk_val("brk_low_cnt", cnt, 40);
        cnt = 0;
        for (int i = 40; i < 60; i++) if (line[i] == 1'b1) cnt++;
        chk_val("brk_high_after", cnt, 20);
        chk_val("brk_busy_start", busy_l[0], 1'b1);
        chk_val("brk_busy_stop", busy_l[43], 1'b1);
        chk_val("brk_busy_idle", busy_l[44], 1'b0);

        // BREAK requested mid-frame: frame finishes, BREAK follows its stop bit.
        fb = 8'($urandom);
        run_line(100, 11, 60, 1'b1, fb);
        chk_val("fb_write_edge", line[0], 1'b1);
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if ((i / CPB) == 0) begin
                if (line[i + 1] != 1'b0) cnt++;
            end else if ((i / CPB) == 9) begin
                if (line[i + 1] != 1'b1) cnt++;
            end else if (line[i + 1] != fb[(i / CPB) - 1]) begin
                cnt++;
            end
        end
        chk_val("fb_frame_bad_bits", cnt, 0);
        cnt = 0;
        for (int i = 41; i < 81; i++) if (line[i] == 1'b0) cnt++;
        chk_val("fb_brk_low_cnt", cnt, 40);
        cnt = 0;
        for (int i = 81; i < 100; i++) if (line[i] == 1'b1) cnt++;
        chk_val("fb_high_after", cnt, 19);
        chk_val("fb_busy_idle", busy_l[85], 1'b0);

        // Reset mid-DATA: line returns high without a clock edge, queue is discarded.
        model_clear();
        step(1'b1, 8'hC3);
        repeat (15) step(1'b0, 8'h00);
        chk_val("rst_mid_pre_low", uart_txd, 1'b0);
        step(1'b1, 8'h77);
        rst = 1'b1;
        #1;
        chk_val("rst_mid_txd",   uart_txd,     1'b1);
        chk_val("rst_mid_empty", tif.tx_empty, 1'b1);
        chk_val("rst_mid_busy",  tif.tx_busy,  1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        repeat (2 * FRAME) step(1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
